// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV32M multiply/divide engine that retires STEP bits per CALC cycle.
// Optional FAST_MUL_EN: multiplies use a single-cycle multiplier and go IDLE -> FIX -> DONE.
module muldiv_unit #(
    parameter int XLEN = 32,
    parameter int STEP = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            StartE,
    input  logic [2:0]      MOpE,
    input  logic [XLEN-1:0] SrcAE,
    input  logic [XLEN-1:0] SrcBE,
    input  logic            FlushE,
    output logic            BusyE,
    output logic            StallMD,
    output logic            DoneE,
    output logic [XLEN-1:0] ResultE
);
    localparam int N  = XLEN / STEP;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic              signed_a, signed_b, a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0]   abs_a, abs_b, div_val, fix_res;
    logic [2*XLEN-1:0] calc_acc, mul_full;
    logic [XLEN:0]     tmp;

    // Divides are signed when funct3 bit 0 is clear; MULHSU only signs SrcAE.
    always_comb begin
        signed_a = MOpE[2] ? !MOpE[0] : (MOpE != 3'd3);
        signed_b = MOpE[2] ? !MOpE[0] : !MOpE[1];
        a_neg    = signed_a & SrcAE[XLEN-1];
        b_neg    = signed_b & SrcBE[XLEN-1];
        abs_a    = a_neg ? -SrcAE : SrcAE;
        abs_b    = b_neg ? -SrcBE : SrcBE;
        div_zero = (SrcBE == '0);
        div_ovf  = !MOpE[0] && (SrcAE == INT_MIN) && (SrcBE == '1);
    end

`ifdef FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    assign fast_prod = (2*XLEN)'(abs_a) * (2*XLEN)'(abs_b);
`endif

    // acc holds {partial product, multiplier} or {partial remainder, dividend/quotient}.
    always_comb begin
        calc_acc = acc_q;
        tmp      = '0;
        for (int i = 0; i < STEP; i++) begin
            if (op_q[2]) begin
                tmp = calc_acc[2*XLEN-1:XLEN-1] - {1'b0, opb_q};
                if (!tmp[XLEN])
                    calc_acc = {tmp[XLEN-1:0], calc_acc[XLEN-2:0], 1'b1};
                else
                    calc_acc = {calc_acc[2*XLEN-2:0], 1'b0};
            end else begin
                tmp      = {1'b0, calc_acc[2*XLEN-1:XLEN]} + (calc_acc[0] ? {1'b0, opb_q} : '0);
                calc_acc = {tmp, calc_acc[XLEN-1:1]};
            end
        end
    end

    always_comb begin
        mul_full = neg_q ? -acc_q : acc_q;
        div_val  = op_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
        if (op_q[2])
            fix_res = neg_q ? -div_val : div_val;
        else if (op_q[1:0] == 2'd0)
            fix_res = mul_full[XLEN-1:0];
        else
            fix_res = mul_full[2*XLEN-1:XLEN];
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (StartE) begin
                    op_d    = MOpE;
                    neg_d   = (MOpE[2] && MOpE[1]) ? a_neg : (a_neg ^ b_neg);
                    acc_d   = {{XLEN{1'b0}}, (MOpE[2] ? abs_a : abs_b)};
                    opb_d   = MOpE[2] ? abs_b : abs_a;
                    cnt_d   = CW'(N - 1);
                    state_d = CALC;
                    if (MOpE[2] && div_zero) begin
                        result_d = MOpE[1] ? SrcAE : '1;
                        state_d  = DONE;
                    end else if (MOpE[2] && div_ovf) begin
                        result_d = MOpE[1] ? '0 : SrcAE;
                        state_d  = DONE;
                    end
`ifdef FAST_MUL_EN
                    else if (!MOpE[2]) begin
                        acc_d   = fast_prod;
                        state_d = FIX;
                    end
`endif
                end
            end
            CALC: begin
                acc_d = calc_acc;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0)
                    state_d = FIX;
            end
            FIX: begin
                result_d = fix_res;
                state_d  = DONE;
            end
            default: state_d = IDLE;
        endcase
        // A flush kills the op and leaves the last architectural result in place.
        if (FlushE) begin
            state_d  = IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            opb_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign BusyE   = (state_q == CALC) || (state_q == FIX);
    assign DoneE   = (state_q == DONE);
    assign StallMD = BusyE || (StartE && (state_q == IDLE));
    assign ResultE = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vector table, flush/reset/back-to-back sequences and randomized ops
// checked against an arithmetic reference model; follows FAST_MUL_EN for multiply latency.
module tb_muldiv_unit;
    localparam int XLEN  = 32;
    localparam int LIMIT = 80;

    logic            clk;
    logic            rst_n;
    logic            StartE;
    logic [2:0]      MOpE;
    logic [XLEN-1:0] SrcAE;
    logic [XLEN-1:0] SrcBE;
    logic            FlushE;
    logic            BusyE;
    logic            StallMD;
    logic            DoneE;
    logic [XLEN-1:0] ResultE;

    int              n_checks = 0;
    int              n_fails  = 0;
    logic [31:0]     last_res = '0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        string       name;
    } vec_t;

    vec_t vecs [15];

    muldiv_unit #(.XLEN(XLEN), .STEP(1)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .StartE  (StartE),
        .MOpE    (MOpE),
        .SrcAE   (SrcAE),
        .SrcBE   (SrcBE),
        .FlushE  (FlushE),
        .BusyE   (BusyE),
        .StallMD (StallMD),
        .DoneE   (DoneE),
        .ResultE (ResultE)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference results straight from the RV32M rules using wide integer arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa, sb, ub;
        logic [63:0] p;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        r  = '0;
        case (op)
            3'd0: begin p = 64'(sa * sb); r = p[31:0]; end
            3'd1: begin p = 64'(sa * sb); r = p[63:32]; end
            3'd2: begin p = 64'(sa * ub); r = p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
            3'd4: r = (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: r = (b == 0) ? a : 32'(sa % sb);
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && (b == 0)) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef FAST_MUL_EN
        if (!op[2]) return 2;
`endif
        return 34;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        StartE = 1'b1;
        MOpE   = op;
        SrcAE  = a;
        SrcBE  = b;
        #1;
    endtask

    // Called in the start cycle; scrambles operands after acceptance and counts cycles to DoneE.
    task automatic waitDone(input string name, input logic [31:0] exp_res, input int lat,
                            input logic exp_stall0);
        int cyc;
        checkOutput({name, " stall@start"}, 32'(StallMD), 32'(exp_stall0));
        @(negedge clk);
        StartE = 1'b0;
        MOpE   = 3'($urandom);
        SrcAE  = $urandom;
        SrcBE  = $urandom;
        cyc    = 1;
        while (DoneE !== 1'b1 && cyc < LIMIT) begin
            checkOutput({name, " stall busy"}, 32'(StallMD), 32'd1);
            @(negedge clk);
            cyc++;
        end
        checkOutput({name, " latency"}, 32'(cyc), 32'(lat));
        checkOutput({name, " result"}, ResultE, exp_res);
        checkOutput({name, " stall@done"}, 32'(StallMD), 32'd0);
        last_res = exp_res;
    endtask

    task automatic finishIdle(input string name);
        @(negedge clk);
        checkOutput({name, " done pulse"}, 32'(DoneE), 32'd0);
        checkOutput({name, " idle busy"}, 32'(BusyE), 32'd0);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        int          done_seen;

        vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, "MUL 7x-3"};
        vecs[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, "MULH min*min"};
        vecs[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, "MULHU max*max"};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, "MULHSU -1*2"};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, "DIV -7/2"};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, "REM -7%2"};
        vecs[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        "DIVU 100/7"};
        vecs[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         "REMU 100%7"};
        vecs[8]  = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, "DIVU 5/0"};
        vecs[9]  = '{3'd6, 32'd5,          32'd0,         32'd5,         "REM 5/0"};
        vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, "DIV ovf"};
        vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         "REM ovf"};
        vecs[12] = '{3'd4, 32'd9,          32'd0,         32'hFFFF_FFFF, "DIV 9/0"};
        vecs[13] = '{3'd7, 32'd9,          32'd0,         32'd9,         "REMU 9/0"};
        vecs[14] = '{3'd0, 32'd3,          32'd4,         32'd12,        "MUL 3x4"};

        rst_n  = 1'b0;
        StartE = 1'b0;
        FlushE = 1'b0;
        MOpE   = '0;
        SrcAE  = '0;
        SrcBE  = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset busy", 32'(BusyE), 32'd0);
        checkOutput("reset done", 32'(DoneE), 32'd0);
        checkOutput("reset stall", 32'(StallMD), 32'd0);
        checkOutput("reset result", ResultE, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
            waitDone(vecs[i].name, vecs[i].res, exp_lat(vecs[i].op, vecs[i].a, vecs[i].b), 1'b1);
            finishIdle(vecs[i].name);
        end

        // Flush in CALC cycle 10, then a new op starts in the very next cycle.
        applyStimulus(3'd4, 32'hFFFF_FFF9, 32'd2);
        checkOutput("flush stall@start", 32'(StallMD), 32'd1);
        @(negedge clk);
        StartE = 1'b0;
        repeat (9) @(negedge clk);
        checkOutput("flush busy before", 32'(BusyE), 32'd1);
        FlushE = 1'b1;
        @(negedge clk);
        FlushE = 1'b0;
        checkOutput("flush busy after", 32'(BusyE), 32'd0);
        checkOutput("flush done after", 32'(DoneE), 32'd0);
        checkOutput("flush result kept", ResultE, last_res);
        applyStimulus(3'd7, 32'd100, 32'd7);
        waitDone("after flush REMU", 32'd2, 34, 1'b1);
        finishIdle("after flush REMU");

        // Flush wins over a simultaneous start, even for a one-cycle special case.
        applyStimulus(3'd5, 32'd5, 32'd0);
        FlushE = 1'b1;
        @(negedge clk);
        StartE = 1'b0;
        FlushE = 1'b0;
        checkOutput("flush prio done", 32'(DoneE), 32'd0);
        checkOutput("flush prio busy", 32'(BusyE), 32'd0);
        checkOutput("flush prio result", ResultE, last_res);
        @(negedge clk);

        // Back-to-back: StartE high in DONE launches the next op without an idle cycle.
        applyStimulus(3'd5, 32'd100, 32'd7);
        waitDone("b2b first", 32'd14, 34, 1'b1);
        applyStimulus(3'd0, 32'd7, 32'hFFFF_FFFD);
        waitDone("b2b second", 32'hFFFF_FFEB, exp_lat(3'd0, 32'd7, 32'hFFFF_FFFD), 1'b0);
        finishIdle("b2b second");

        // Reset mid-operation aborts without a later DoneE.
        applyStimulus(3'd5, 32'd1000, 32'd3);
        @(negedge clk);
        StartE = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset busy", 32'(BusyE), 32'd0);
        checkOutput("midreset result", ResultE, 32'd0);
        last_res = '0;
        @(negedge clk);
        rst_n     = 1'b1;
        done_seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (DoneE === 1'b1) done_seen++;
        end
        checkOutput("midreset no done", 32'(done_seen), 32'd0);

        for (int k = 0; k < 30; k++) begin
            rop = 3'($urandom);
            ra  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            applyStimulus(rop, ra, rb);
            waitDone($sformatf("rand%0d op%0d", k, rop), ref_model(rop, ra, rb),
                     exp_lat(rop, ra, rb), 1'b1);
            finishIdle($sformatf("rand%0d", k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fails);
        $finish;
    end
endmodule
